banner_scan_ctrl: RTL and testbench
===================================

// Module: banner_scan_ctrl
// PURPOSE
//  Sequences the 1440x39 title-banner bitmap ROM (6-bit row address, 1440-bit row word, MSB = leftmost pixel).
//  Per frame: fetches rows ROW_FIRST..ROW_LAST in order, latches each row, streams a WIN_W-pixel window to the display.
//  The window starts at a horizontal scroll offset that auto-advances per frame and wraps modulo ROM_W.
//  Sits between the banner ROM and the VGA pixel mixer on the title screen.
// PARAMETERS
//  ROM_W        1440  pixels per ROM row (row word width)
//  ROW_FIRST    1     first ROM address streamed per frame
//  ROW_LAST     39    last ROM address streamed per frame
//  WIN_W        640   pixels emitted per row (window width, <= ROM_W)
//  SCROLL_STEP  4     offset increment per completed frame when scroll_en=1
// PORTS
//  clk         in   1      system clock
//  rst         in   1      asynchronous reset, active-high
//  start       in   1      begin one frame scan; honoured only when busy=0
//  scroll_en   in   1      advance offset at frame end
//  scroll_set  in   1      load scroll_val into offset; honoured only when busy=0
//  scroll_val  in   11     new offset; values >= ROM_W load 0
//  rom_adder   out  6      ROM row address (registered)
//  rom_data    in   1440   ROM row word (combinational ROM, valid same cycle as rom_adder)
//  pix_valid   out  1      pixel output valid
//  pix_ready   in   1      downstream accepts pixel
//  pix_bit     out  1      pixel value (1 = lit)
//  pix_row     out  6      ROM row of current pixel
//  pix_col     out  11     window column 0..WIN_W-1
//  scroll_off  out  11     current offset 0..ROM_W-1
//  busy        out  1      frame scan in progress
//  frame_done  out  1      one-cycle pulse after last pixel of ROW_LAST accepted
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; rom_adder=0, pix_valid=0, pix_bit=0, pix_row=0, pix_col=0,
//   scroll_off=0, busy=0, frame_done=0. Reset mid-frame abandons the frame; no frame_done.
//  FSM: IDLE -(start)-> FETCH -> STREAM -(last col accepted, row<ROW_LAST)-> FETCH; -(last col, row=ROW_LAST)-> IDLE.
//  IDLE: rom_adder=0; on start: rom_adder<=ROW_FIRST, busy<=1, go FETCH. start when busy=1 ignored.
//  FETCH (1 cycle): row_buf<=rom_data; pix_row<=rom_adder; pix_col<=0; pix_valid<=1 entering STREAM.
//   Latency: start sampled at edge t -> FETCH in cycle t+1 -> first pix_valid in cycle t+2.
//  STREAM: ROM x = scroll_off+pix_col, minus ROM_W if >= ROM_W; pix_bit = row_buf[ROM_W-1-x].
//   Handshake: transfer on pix_valid&pix_ready; while pix_valid&!pix_ready, pix_bit/pix_row/pix_col held stable.
//   On transfer with pix_col<WIN_W-1: pix_col+1, pix_valid stays 1 (back-to-back, 1 pixel/cycle).
//   On transfer with pix_col=WIN_W-1: pix_valid<=0; row<ROW_LAST -> rom_adder+1, FETCH (1 bubble cycle);
//   row=ROW_LAST -> IDLE, busy<=0, frame_done<=1 one cycle, rom_adder<=0.
//  Scroll: at frame end edge, scroll_en=1 -> scroll_off<=(scroll_off+SCROLL_STEP) mod ROM_W; offset constant within frame.
//   scroll_set in IDLE loads scroll_val (>=ROM_W -> 0); start+scroll_set in the same cycle: set applies first, frame uses new offset.
//  Widths: x sum computed in 12 bits before wrap; all counters saturate never, wrap per rules above.
// STRUCTURE
//  Shared include banner_defs.vh: ROM_W, ROW_FIRST, ROW_LAST, WIN_W, FSM state localparams (IDLE/FETCH/STREAM), col width 11.
//  Sub-module banner_col_sel: combinational wrap-add (scroll_off, pix_col) -> x, and 1440:1 bit select from row_buf.
//  Top: FSM, row/col counters, row_buf register, scroll register, output registers.
// TESTING
//  T1 reset, scroll_off=0, pix_ready=1, start -> rom_adder=1 at t+1, pix_valid at t+2, 39*640=24960 transfers, frame_done 1 pulse, busy 0 after.
//  T2 scroll 0, row 2: cols 0..11 pix_bit=0, col 12 pix_bit=1 (row 2 word begins 16'h0008); rows 1 and 39 all zero.
//  T3 pix_ready low 5 cycles at row 5 col 100 -> outputs frozen, resume at col 100, no column skipped or duplicated.
//  T4 scroll_set scroll_val=1436 then start -> row 2 cols 0..3 map x=1436..1439, col 4 -> x=0, lit pixel at col 16.
//  T5 scroll_en=1, SCROLL_STEP=4, scroll_off=1438 -> after frame_done scroll_off=2; scroll_val=1500 -> loads 0.
//  T6 rst pulse mid-STREAM row 20 -> all outputs reset immediately, no frame_done; next start fetches row 1; start while busy ignored.

Source files
------------

// File: rtl/banner_scan_ctrl_pkg.sv
// Shared constants, state encoding and wrap-add helper for the title-banner scanner.
package banner_scan_ctrl_pkg;

    localparam int ROM_W = 1440;      // pixels per ROM row
    localparam int COL_W = 11;        // column / offset width
    localparam int ROW_W = 6;         // ROM address width
    localparam int SUM_W = 12;        // offset + column sum width before wrap

    localparam logic [SUM_W-1:0] ROM_W_SUM   = 12'd1440;
    localparam logic [COL_W-1:0] ROM_W_COL   = 11'd1440;
    localparam logic [COL_W-1:0] ROM_MSB_IDX = 11'd1439;
    localparam logic [ROW_W-1:0] ROW_FIRST   = 6'd1;
    localparam logic [ROW_W-1:0] ROW_LAST    = 6'd39;
    localparam logic [COL_W-1:0] WIN_LAST    = 11'd639;   // WIN_W - 1
    localparam logic [COL_W-1:0] SCROLL_STEP = 11'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // (a + b) mod ROM_W for a < ROM_W and b small enough that one subtraction suffices
    function automatic logic [COL_W-1:0] wrap_add(input logic [COL_W-1:0] a,
                                                  input logic [COL_W-1:0] b);
        logic [SUM_W-1:0] sum_s;
        sum_s = {1'b0, a} + {1'b0, b};
        if (sum_s >= ROM_W_SUM) begin
            wrap_add = sum_s[COL_W-1:0] - ROM_W_SUM[COL_W-1:0];
        end else begin
            wrap_add = sum_s[COL_W-1:0];
        end
    endfunction

endpackage

// File: rtl/banner_scan_ctrl_col_sel.sv
// Maps a window column to its wrapped ROM x position and picks that pixel from a row word.
module banner_scan_ctrl_col_sel
    import banner_scan_ctrl_pkg::*;
(
    input  logic [ROM_W-1:0] row_word,
    input  logic [COL_W-1:0] off,
    input  logic [COL_W-1:0] col,
    output logic             bit_val
);

    logic [COL_W-1:0] x_s;

    // wrap the scrolled column into the ROM row, then select MSB-first
    always_comb begin
        x_s     = wrap_add(off, col);
        bit_val = row_word[ROM_MSB_IDX - x_s];
    end

endmodule

// File: rtl/banner_scan_ctrl.sv
// Title-banner scan controller: fetches ROM rows per frame and streams a scrolled pixel window.
module banner_scan_ctrl
    import banner_scan_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             scroll_en,
    input  logic             scroll_set,
    input  logic [COL_W-1:0] scroll_val,
    output logic [ROW_W-1:0] rom_adder,
    input  logic [ROM_W-1:0] rom_data,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             pix_bit,
    output logic [ROW_W-1:0] pix_row,
    output logic [COL_W-1:0] pix_col,
    output logic [COL_W-1:0] scroll_off,
    output logic             busy,
    output logic             frame_done
);

    state_t           state_r;
    logic [ROM_W-1:0] row_buf_r;
    logic [ROM_W-1:0] sel_word_s;
    logic [COL_W-1:0] sel_col_s;
    logic             sel_bit_s;

    // pixel lookahead: first pixel straight from the ROM in FETCH, next column from row_buf otherwise
    always_comb begin
        if (state_r == ST_FETCH) begin
            sel_word_s = rom_data;
            sel_col_s  = 11'd0;
        end else begin
            sel_word_s = row_buf_r;
            sel_col_s  = pix_col + 11'd1;
        end
    end

    banner_scan_ctrl_col_sel u_col_sel (
        .row_word (sel_word_s),
        .off      (scroll_off),
        .col      (sel_col_s),
        .bit_val  (sel_bit_s)
    );

    // frame sequencer with row/column counters, row buffer, scroll register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            row_buf_r  <= '0;
            rom_adder  <= 6'd0;
            pix_valid  <= 1'b0;
            pix_bit    <= 1'b0;
            pix_row    <= 6'd0;
            pix_col    <= 11'd0;
            scroll_off <= 11'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    rom_adder <= 6'd0;
                    // a set in the same cycle as start lands before the first fetch uses it
                    if (scroll_set) begin
                        scroll_off <= (scroll_val >= ROM_W_COL) ? 11'd0 : scroll_val;
                    end
                    if (start) begin
                        rom_adder <= ROW_FIRST;
                        busy      <= 1'b1;
                        state_r   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    row_buf_r <= rom_data;
                    pix_row   <= rom_adder;
                    pix_col   <= 11'd0;
                    pix_bit   <= sel_bit_s;
                    pix_valid <= 1'b1;
                    state_r   <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (pix_valid && pix_ready) begin
                        if (pix_col < WIN_LAST) begin
                            pix_col <= pix_col + 11'd1;
                            pix_bit <= sel_bit_s;
                        end else begin
                            pix_valid <= 1'b0;
                            if (pix_row < ROW_LAST) begin
                                rom_adder <= rom_adder + 6'd1;
                                state_r   <= ST_FETCH;
                            end else begin
                                rom_adder  <= 6'd0;
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                                state_r    <= ST_IDLE;
                                if (scroll_en) begin
                                    scroll_off <= wrap_add(scroll_off, SCROLL_STEP);
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    pix_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_banner_scan_ctrl.sv
// Self-checking bench for banner_scan_ctrl: table-driven scroll loads, full-frame scoreboard,
// stall, wrap, auto-scroll and mid-frame reset sequences.
module tb_banner_scan_ctrl;

    localparam int ROM_W  = 1440;
    localparam int WIN_W  = 640;
    localparam int ROW_F  = 1;
    localparam int ROW_L  = 39;
    localparam int NPIX   = (ROW_L - ROW_F + 1) * WIN_W;   // 24960

    logic              clk;
    logic              rst;
    logic              start;
    logic              scroll_en;
    logic              scroll_set;
    logic [10:0]       scroll_val;
    logic [5:0]        rom_adder;
    logic [ROM_W-1:0]  rom_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_bit;
    logic [5:0]        pix_row;
    logic [10:0]       pix_col;
    logic [10:0]       scroll_off;
    logic              busy;
    logic              frame_done;

    logic [ROM_W-1:0]  rom_m [0:63];
    assign rom_data = rom_m[rom_adder];

    banner_scan_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .scroll_en  (scroll_en),
        .scroll_set (scroll_set),
        .scroll_val (scroll_val),
        .rom_adder  (rom_adder),
        .rom_data   (rom_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_bit    (pix_bit),
        .pix_row    (pix_row),
        .pix_col    (pix_col),
        .scroll_off (scroll_off),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    int          model_off = 0;
    int          mon_k     = 0;
    int          row_err   = 0;
    int          fd_cnt    = 0;
    int          xfer_cnt  = 0;
    logic        stall_q   = 1'b0;
    logic [17:0] hold_q    = '0;

    // Expected pixel k of a frame: row ROW_F + k/WIN_W, column k%WIN_W, ROM x = (off+col) mod ROM_W
    always @(negedge clk) begin
        int row_e, col_e, x_e;
        logic bit_e;
        if (frame_done) begin
            fd_cnt++;
            chk("frame_done_after_last_pixel", 64'(mon_k), 64'(NPIX));
        end
        if (stall_q) begin
            chk("hold_while_stalled", {45'd0, pix_valid, pix_bit, pix_row, pix_col}, {45'd0, 1'b1, hold_q});
        end
        if (!rst && pix_valid && pix_ready) begin
            row_e = ROW_F + mon_k / WIN_W;
            col_e = mon_k % WIN_W;
            x_e   = (model_off + col_e) % ROM_W;
            bit_e = (row_e < 64) ? rom_m[row_e][ROM_W-1-x_e] : 1'b0;
            if ({pix_row, pix_col, pix_bit} !== {6'(row_e), 11'(col_e), bit_e}) begin
                row_err++;
            end
            mon_k++;
            xfer_cnt++;
            if (col_e == WIN_W - 1) begin
                chk($sformatf("row%0d_pixel_errors", row_e), 64'(row_err), 64'd0);
                row_err = 0;
            end
        end
        stall_q = !rst && pix_valid && !pix_ready;
        hold_q  = {pix_bit, pix_row, pix_col};
        if (rst || !busy) begin
            mon_k   = 0;
            row_err = 0;
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [10:0] val;
        logic [10:0] exp_off;
    } scroll_vec_t;

    scroll_vec_t tbl [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {28'd0, rom_adder, pix_valid, pix_bit, pix_row, pix_col, scroll_off, busy, frame_done}, 64'd0);
    endtask

    initial begin
        int cyc;
        int fd_before;
        int xf_before;
        bit stall_done;

        rst = 1'b1; start = 1'b0; scroll_en = 1'b0; scroll_set = 1'b0;
        scroll_val = 11'd0; pix_ready = 1'b0;

        // ROM image: rows 1 and 39 blank, row 2 has a single lit pixel at x=12, others random
        for (int r = 0; r < 64; r++) begin
            for (int j = 0; j < ROM_W / 32; j++) rom_m[r][j*32 +: 32] = $urandom;
        end
        rom_m[1]  = '0;
        rom_m[39] = '0;
        rom_m[2]  = '0;
        rom_m[2][ROM_W-1-12] = 1'b1;

        tbl[0] = '{11'd720,  11'd720};
        tbl[1] = '{11'd1439, 11'd1439};
        tbl[2] = '{11'd1440, 11'd0};
        tbl[3] = '{11'd1438, 11'd1438};
        tbl[4] = '{11'd1500, 11'd0};
        tbl[5] = '{11'd1,    11'd1};
        tbl[6] = '{11'd2047, 11'd0};
        tbl[7] = '{11'd0,    11'd0};

        // reset state
        repeat (2) tick();
        chk_all_zero("reset_outputs");
        rst = 1'b0;
        tick();
        chk_all_zero("idle_after_reset");

        // table-driven scroll loads while idle
        for (int i = 0; i < 8; i++) begin
            scroll_set = 1'b1;
            scroll_val = tbl[i].val;
            tick();
            scroll_set = 1'b0;
            chk($sformatf("scroll_set_%0d", tbl[i].val), 64'(scroll_off), 64'(tbl[i].exp_off));
            chk("busy_idle_on_set", 64'(busy), 64'd0);
        end

        // full frame, offset 0, always ready: latency, counts, single frame_done
        model_off = 0;
        pix_ready = 1'b1;
        xf_before = xfer_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("fetch_addr_t1", 64'(rom_adder), 64'd1);
        chk("busy_t1", 64'(busy), 64'd1);
        chk("no_valid_t1", 64'(pix_valid), 64'd0);
        tick();
        chk("first_valid_t2", {45'd0, pix_valid, pix_row, pix_col}, {45'd0, 1'b1, 6'd1, 11'd0});
        cyc = 0;
        while (!frame_done && cyc < 30000) begin tick(); cyc++; end
        chk("frameA_done_seen", 64'(frame_done), 64'd1);
        repeat (3) tick();
        chk("frameA_busy_clear", 64'(busy), 64'd0);
        chk("frameA_done_pulses", 64'(fd_cnt), 64'd1);
        chk("frameA_transfers", 64'(xfer_cnt - xf_before), 64'(NPIX));
        chk("frameA_rom_adder_idle", 64'(rom_adder), 64'd0);
        chk("frameA_offset_kept", 64'(scroll_off), 64'd0);

        // wrapped window at offset 1436, then reset in the middle of row 20
        scroll_set = 1'b1;
        scroll_val = 11'd1436;
        tick();
        scroll_set = 1'b0;
        model_off = 1436;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!(pix_valid && pix_row == 6'd20 && pix_col == 11'd50) && cyc < 20000) begin
            tick(); cyc++;
        end
        chk("reached_row20", {53'd0, pix_row, pix_col}, {53'd0, 6'd20, 11'd50});
        fd_before = fd_cnt;
        rst = 1'b1;
        #2;
        chk_all_zero("async_reset_mid_frame");
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("no_frame_done_after_abort", 64'(fd_cnt), 64'(fd_before));
        chk("idle_after_abort", 64'(busy), 64'd0);

        // start + set in the same cycle, auto-scroll, ignored start/set while busy, stall at row 5 col 100
        scroll_en  = 1'b1;
        scroll_set = 1'b1;
        scroll_val = 11'd1438;
        model_off  = 1438;
        fd_before  = fd_cnt;
        xf_before  = xfer_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        scroll_set = 1'b0;
        chk("restart_fetch_row1", 64'(rom_adder), 64'd1);
        chk("set_before_frame", 64'(scroll_off), 64'd1438);
        tick();
        start = 1'b1;
        scroll_set = 1'b1;
        scroll_val = 11'd5;
        tick();
        start = 1'b0;
        scroll_set = 1'b0;
        chk("set_ignored_busy", 64'(scroll_off), 64'd1438);
        chk("start_ignored_busy", {58'd0, pix_row}, {58'd0, 6'd1});
        stall_done = 1'b0;
        cyc = 0;
        while (!frame_done && cyc < 40000) begin
            if (!stall_done && pix_valid && pix_row == 6'd5 && pix_col == 11'd100) begin
                pix_ready = 1'b0;
                repeat (5) tick();
                chk("stall_frozen_col", {53'd0, pix_row, pix_col}, {53'd0, 6'd5, 11'd100});
                stall_done = 1'b1;
                pix_ready = 1'b1;
            end else begin
                pix_ready = ($urandom_range(0, 7) != 0);
            end
            tick();
            cyc++;
        end
        chk("frameC_done_seen", 64'(frame_done), 64'd1);
        chk("stall_exercised", 64'(stall_done), 64'd1);
        pix_ready = 1'b1;
        repeat (3) tick();
        chk("auto_scroll_wrap", 64'(scroll_off), 64'd2);
        chk("frameC_done_pulses", 64'(fd_cnt - fd_before), 64'd1);
        chk("frameC_transfers", 64'(xfer_cnt - xf_before), 64'(NPIX));
        chk("frameC_busy_clear", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
